// File: rtl/cardinal_local_port.sv
// Router-side end of the NIC<->router link: one single-entry buffer per VC in each direction.
// The NIC side is served on the VC equal to net_polarity, and the router core on the opposite VC.
module cardinal_local_port #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              net_polarity,
    input  logic              nic_so,
    output logic              nic_ro,
    input  logic [DATA_W-1:0] nic_do,
    output logic              nic_si,
    input  logic              nic_ri,
    output logic [DATA_W-1:0] nic_di,
    output logic              rtr_so,
    input  logic              rtr_ro,
    output logic [DATA_W-1:0] rtr_do,
    input  logic              rtr_si,
    output logic              rtr_ri,
    input  logic [DATA_W-1:0] rtr_di,
    output logic              vc_err,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt
);
    localparam int VC_BIT = DATA_W - 1;

    logic              pol;
    logic              p;
    logic              q;
    logic [1:0]        ib_full;
    logic [1:0]        eb_full;
    logic [DATA_W-1:0] ib [2];
    logic [DATA_W-1:0] eb [2];

    logic nic_take;
    logic nic_bad;
    logic rtr_take;
    logic rtr_bad;
    logic in_fire;
    logic out_fire;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    assign p            = pol;
    assign q            = ~pol;
    assign net_polarity = pol;

    // Handshake outputs depend only on registered state and the current phase.
    assign nic_ro = ~ib_full[p];
    assign rtr_so = ib_full[q];
    assign rtr_do = ib_full[q] ? ib[q] : '0;
    assign rtr_ri = ~eb_full[q];
    assign nic_si = eb_full[p];
    assign nic_di = eb_full[p] ? eb[p] : '0;

    assign nic_take = nic_so & nic_ro & (nic_do[VC_BIT] == p);
    assign nic_bad  = nic_so & (nic_do[VC_BIT] != p);
    assign rtr_take = rtr_si & rtr_ri & (rtr_di[VC_BIT] == q);
    assign rtr_bad  = rtr_si & (rtr_di[VC_BIT] == p);
    assign in_fire  = rtr_so & rtr_ro;
    assign out_fire = nic_si & nic_ri;

    // Fill and drain of one buffer happen in opposite phases, so the bit updates never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pol     <= 1'b0;
            ib_full <= '0;
            eb_full <= '0;
            ib[0]   <= '0;
            ib[1]   <= '0;
            eb[0]   <= '0;
            eb[1]   <= '0;
            vc_err  <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            pol <= ~pol;
            if (nic_take) begin
                ib[p]      <= nic_do;
                ib_full[p] <= 1'b1;
            end
            if (in_fire) begin
                ib_full[q] <= 1'b0;
                in_cnt     <= cnt_inc(in_cnt);
            end
            if (rtr_take) begin
                eb[q]      <= rtr_di;
                eb_full[q] <= 1'b1;
            end
            if (out_fire) begin
                eb_full[p] <= 1'b0;
                out_cnt    <= cnt_inc(out_cnt);
            end
            if (nic_bad || rtr_bad)
                vc_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cardinal_local_port.sv
// Directed bench for cardinal_local_port; packets are scoreboarded through per-direction queues.
module tb_cardinal_local_port;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              net_polarity;
    logic              nic_so;
    logic              nic_ro;
    logic [DATA_W-1:0] nic_do;
    logic              nic_si;
    logic              nic_ri;
    logic [DATA_W-1:0] nic_di;
    logic              rtr_so;
    logic              rtr_ro;
    logic [DATA_W-1:0] rtr_do;
    logic              rtr_si;
    logic              rtr_ri;
    logic [DATA_W-1:0] rtr_di;
    logic              vc_err;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;

    int total = 0;
    int bad   = 0;
    logic exp_pol;
    logic [DATA_W-1:0] ing_q[$];
    logic [DATA_W-1:0] egr_q[$];

    cardinal_local_port #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .net_polarity(net_polarity),
        .nic_so(nic_so), .nic_ro(nic_ro), .nic_do(nic_do),
        .nic_si(nic_si), .nic_ri(nic_ri), .nic_di(nic_di),
        .rtr_so(rtr_so), .rtr_ro(rtr_ro), .rtr_do(rtr_do),
        .rtr_si(rtr_si), .rtr_ri(rtr_ri), .rtr_di(rtr_di),
        .vc_err(vc_err), .in_cnt(in_cnt), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Compares handshakes that will complete at the coming edge, then advances one cycle.
    task automatic cyc();
        logic [DATA_W-1:0] e;
        if (rtr_so && rtr_ro) begin
            chk("ing_pending", 64'(ing_q.size() > 0), 64'd1);
            if (ing_q.size() > 0) begin
                e = ing_q.pop_front();
                chk("rtr_do", rtr_do, e);
            end
        end
        if (nic_si && nic_ri) begin
            chk("egr_pending", 64'(egr_q.size() > 0), 64'd1);
            if (egr_q.size() > 0) begin
                e = egr_q.pop_front();
                chk("nic_di", nic_di, e);
            end
        end
        @(negedge clk);
        exp_pol = ~exp_pol;
    endtask

    task automatic to_phase(input logic ph);
        if (exp_pol != ph) cyc();
    endtask

    initial begin
        reset  = 1'b1;
        nic_so = 1'b0; nic_do = '0; nic_ri = 1'b0;
        rtr_si = 1'b0; rtr_di = '0; rtr_ro = 1'b0;
        exp_pol = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state and polarity sequence
        chk("rst_pol", 64'(net_polarity), 64'd0);
        chk("rst_nic_ro", 64'(nic_ro), 64'd1);
        chk("rst_rtr_ri", 64'(rtr_ri), 64'd1);
        chk("rst_nic_si", 64'(nic_si), 64'd0);
        chk("rst_rtr_so", 64'(rtr_so), 64'd0);
        chk("rst_in_cnt", 64'(in_cnt), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_vc_err", 64'(vc_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("pol_seq", 64'(net_polarity), 64'(i % 2));
            cyc();
        end

        // single VC0 packet NIC -> router
        to_phase(1'b0);
        nic_so = 1'b1; nic_do = 64'd1234; ing_q.push_back(64'd1234);
        chk("t2_nic_ro", 64'(nic_ro), 64'd1);
        cyc();
        nic_so = 1'b0;
        chk("t2_rtr_so", 64'(rtr_so), 64'd1);
        chk("t2_rtr_do", rtr_do, 64'd1234);
        rtr_ro = 1'b1;
        cyc();
        rtr_ro = 1'b0;
        chk("t2_in_cnt", 64'(in_cnt), 64'd1);
        chk("t2_rtr_so_after", 64'(rtr_so), 64'd0);

        // VC1 held by core back-pressure, VC0 still accepted
        to_phase(1'b1);
        nic_so = 1'b1; nic_do = {1'b1, 63'd4}; ing_q.push_back({1'b1, 63'd4});
        cyc();
        nic_do = 64'd1111; ing_q.push_back(64'd1111);
        chk("t3_vc0_nic_ro", 64'(nic_ro), 64'd1);
        chk("t3_rtr_so_a", 64'(rtr_so), 64'd1);
        cyc();
        nic_so = 1'b0;
        chk("t3_nic_ro_b", 64'(nic_ro), 64'd0);
        chk("t3_rtr_so_b", 64'(rtr_so), 64'd1);
        cyc();
        chk("t3_rtr_so_c", 64'(rtr_so), 64'd1);
        chk("t3_nic_ro_c", 64'(nic_ro), 64'd0);
        cyc();
        chk("t3_nic_ro_d", 64'(nic_ro), 64'd0);
        cyc();
        rtr_ro = 1'b1;
        cyc();
        cyc();
        rtr_ro = 1'b0;
        chk("t3_in_cnt", 64'(in_cnt), 64'd3);
        chk("t3_rtr_so_done", 64'(rtr_so), 64'd0);
        chk("t3_nic_ro_done", 64'(nic_ro), 64'd1);

        // router -> NIC with one NIC stall
        to_phase(1'b1);
        rtr_si = 1'b1; rtr_di = 64'd1738; egr_q.push_back(64'd1738);
        chk("t4_rtr_ri", 64'(rtr_ri), 64'd1);
        cyc();
        rtr_si = 1'b0;
        chk("t4_nic_si", 64'(nic_si), 64'd1);
        chk("t4_nic_di", nic_di, 64'd1738);
        cyc();
        chk("t4_nic_si_off", 64'(nic_si), 64'd0);
        chk("t4_nic_di_off", nic_di, 64'd0);
        chk("t4_rtr_ri_full", 64'(rtr_ri), 64'd0);
        cyc();
        chk("t4_reoffer", 64'(nic_si), 64'd1);
        nic_ri = 1'b1;
        cyc();
        nic_ri = 1'b0;
        chk("t4_out_cnt", 64'(out_cnt), 64'd1);

        // wrong-VC packet from NIC
        to_phase(1'b0);
        chk("t5_vc_err_pre", 64'(vc_err), 64'd0);
        nic_so = 1'b1; nic_do = {1'b1, 63'd0};
        cyc();
        nic_so = 1'b0;
        chk("t5_vc_err", 64'(vc_err), 64'd1);
        chk("t5_rtr_so_a", 64'(rtr_so), 64'd0);
        cyc();
        chk("t5_rtr_so_b", 64'(rtr_so), 64'd0);
        chk("t5_vc_err_sticky", 64'(vc_err), 64'd1);

        // fill all four buffers, then reset mid-operation
        to_phase(1'b0);
        nic_so = 1'b1; nic_do = 64'd5;
        rtr_si = 1'b1; rtr_di = {1'b1, 63'd7};
        cyc();
        nic_do = {1'b1, 63'd6};
        rtr_di = 64'd8;
        cyc();
        nic_so = 1'b0; rtr_si = 1'b0;
        chk("t6_rtr_so_full", 64'(rtr_so), 64'd1);
        chk("t6_nic_si_full", 64'(nic_si), 64'd1);
        chk("t6_nic_ro_full", 64'(nic_ro), 64'd0);
        reset = 1'b1;
        #1;
        chk("t6_rtr_so_rst", 64'(rtr_so), 64'd0);
        chk("t6_nic_si_rst", 64'(nic_si), 64'd0);
        chk("t6_pol_rst", 64'(net_polarity), 64'd0);
        chk("t6_in_cnt_rst", 64'(in_cnt), 64'd0);
        chk("t6_out_cnt_rst", 64'(out_cnt), 64'd0);
        chk("t6_vc_err_rst", 64'(vc_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_pol = 1'b0;
        chk("t6_nic_si_p0", 64'(nic_si), 64'd0);
        chk("t6_rtr_so_p0", 64'(rtr_so), 64'd0);
        cyc();
        chk("t6_nic_si_p1", 64'(nic_si), 64'd0);
        chk("t6_rtr_so_p1", 64'(rtr_so), 64'd0);

        // counter wrap: five packets through a 2-bit counter
        rtr_ro = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nic_so = 1'b1;
            nic_do = {exp_pol, 63'(100 + i)};
            ing_q.push_back({exp_pol, 63'(100 + i)});
            cyc();
        end
        nic_so = 1'b0;
        cyc();
        rtr_ro = 1'b0;
        cyc();
        chk("t6_in_cnt_wrap", 64'(in_cnt), 64'd1);
        chk("t6_ing_q_empty", 64'(ing_q.size()), 64'd0);
        chk("t6_egr_q_empty", 64'(egr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
